// File: rtl/vector_dot_engine_if.sv
// Request, memory-read and result-write signals of the dot-product engine.
// The engine connects through the slave modport; the requester/memory side uses master.
interface vector_dot_engine_if #(
    parameter int DW      = 4,
    parameter int AW      = 5,
    parameter int MAX_LEN = 4
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int RW = 2 * DW + $clog2(MAX_LEN);

    // request
    logic          start;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;

    // memory read port
    logic          mem_rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    // result write port and status
    logic          mem_wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] result;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, base_a, base_b, dst_addr, len, rd_data_a, rd_data_b,
        output mem_rd_en, rd_addr_a, rd_addr_b, mem_wr_en, wr_addr, result,
               busy, done, err
    );

    modport master (
        output start, base_a, base_b, dst_addr, len, rd_data_a, rd_data_b,
        input  mem_rd_en, rd_addr_a, rd_addr_b, mem_wr_en, wr_addr, result,
               busy, done, err
    );
endinterface

// File: rtl/vector_dot_engine.sv
// Dot-product engine: streams two vectors out of a 1-cycle-latency memory,
// multiply-accumulates them and writes the sum to a destination address.
// Sequence per request: IDLE -> FETCH (len cycles) -> DRAIN -> WRITE -> IDLE.
module vector_dot_engine #(
    parameter int DW      = 4,
    parameter int AW      = 5,
    parameter int MAX_LEN = 4,
    parameter int SIGNED  = 0
) (
    input  logic                clk,
    input  logic                rst,
    vector_dot_engine_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int RW = 2 * DW + $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [AW-1:0] r_dst;
    logic [RW-1:0] r_acc;
    logic          r_rd_q;      // read issued last cycle: rd_data is valid now
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr_a;
    logic [AW-1:0] r_rd_addr_b;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [RW-1:0] r_result;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [2*DW-1:0] w_prod_raw;
    logic [RW-1:0]   w_prod;
    logic [RW-1:0]   w_sum;

    // Full-width product of the current read data, extended to the accumulator width
    always_comb begin
        w_prod_raw = '0;
        w_prod     = '0;
        if (SIGNED != 0) begin
            w_prod_raw = $signed({{DW{bus.rd_data_a[DW-1]}}, bus.rd_data_a})
                       * $signed({{DW{bus.rd_data_b[DW-1]}}, bus.rd_data_b});
            w_prod     = {{(RW-2*DW){w_prod_raw[2*DW-1]}}, w_prod_raw};
        end else begin
            w_prod_raw = {{DW{1'b0}}, bus.rd_data_a} * {{DW{1'b0}}, bus.rd_data_b};
            w_prod     = {{(RW-2*DW){1'b0}}, w_prod_raw};
        end
        w_sum = r_acc + w_prod;
    end

    // Control FSM with all outputs registered; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_dst       <= '0;
            r_acc       <= '0;
            r_rd_q      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rd_q <= r_rd_en;
            case (r_state)
                S_IDLE: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.start) begin
                        if (bus.len > LW'(MAX_LEN)) begin
                            // rejected request: flag it, touch nothing else
                            r_err <= 1'b1;
                        end else begin
                            r_err  <= 1'b0;
                            r_acc  <= '0;
                            r_len  <= bus.len;
                            r_idx  <= '0;
                            r_dst  <= bus.dst_addr;
                            r_busy <= 1'b1;
                            if (bus.len == '0) begin
                                // empty vector: straight to the write of a zero sum
                                r_state   <= S_WRITE;
                                r_result  <= '0;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= bus.dst_addr;
                                r_done    <= 1'b1;
                            end else begin
                                r_state     <= S_FETCH;
                                r_rd_en     <= 1'b1;
                                r_rd_addr_a <= bus.base_a;
                                r_rd_addr_b <= bus.base_b;
                            end
                        end
                    end
                end

                S_FETCH: begin
                    if (r_rd_q) begin
                        r_acc <= w_sum;
                    end
                    if (r_idx == r_len - LW'(1)) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_idx       <= r_idx + LW'(1);
                        r_rd_addr_a <= r_rd_addr_a + AW'(1);
                        r_rd_addr_b <= r_rd_addr_b + AW'(1);
                    end
                end

                S_DRAIN: begin
                    // last product arrives now; publish the final sum for WRITE
                    r_acc     <= w_sum;
                    r_result  <= w_sum;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_dst;
                    r_done    <= 1'b1;
                    r_state   <= S_WRITE;
                end

                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.mem_wr_en = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_vector_dot_engine.sv
// Testbench for vector_dot_engine: an unsigned and a signed instance share one
// memory image and one request stream; a scoreboard holds the expected reads
// and writes and a monitor compares them as the engines present them.
module tb_vector_dot_engine;
    localparam int DW      = 4;
    localparam int AW      = 5;
    localparam int MAX_LEN = 4;
    localparam int LW      = $clog2(MAX_LEN) + 1;
    localparam int RW      = 2 * DW + $clog2(MAX_LEN);
    localparam int MEMN    = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start;
    logic [AW-1:0] ba_s;
    logic [AW-1:0] bb_s;
    logic [AW-1:0] dst_s;
    logic [LW-1:0] len_s;

    logic [DW-1:0] mem [MEMN];
    logic [DW-1:0] rda0, rdb0, rda1, rdb1;

    vector_dot_engine_if #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) u_if0 ();
    vector_dot_engine_if #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) u_if1 ();

    assign u_if0.start = start;    assign u_if1.start = start;
    assign u_if0.base_a = ba_s;    assign u_if1.base_a = ba_s;
    assign u_if0.base_b = bb_s;    assign u_if1.base_b = bb_s;
    assign u_if0.dst_addr = dst_s; assign u_if1.dst_addr = dst_s;
    assign u_if0.len = len_s;      assign u_if1.len = len_s;
    assign u_if0.rd_data_a = rda0; assign u_if0.rd_data_b = rdb0;
    assign u_if1.rd_data_a = rda1; assign u_if1.rd_data_b = rdb1;

    vector_dot_engine #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN), .SIGNED(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0)
    );

    vector_dot_engine #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN), .SIGNED(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1)
    );

    // 1-cycle-latency memory; data outside a read cycle is garbage on purpose
    always @(posedge clk) begin
        rda0 <= u_if0.mem_rd_en ? mem[u_if0.rd_addr_a] : DW'($urandom);
        rdb0 <= u_if0.mem_rd_en ? mem[u_if0.rd_addr_b] : DW'($urandom);
        rda1 <= u_if1.mem_rd_en ? mem[u_if1.rd_addr_a] : DW'($urandom);
        rdb1 <= u_if1.mem_rd_en ? mem[u_if1.rd_addr_b] : DW'($urandom);
    end

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } rd_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [RW-1:0] r0;
        logic [RW-1:0] r1;
    } wr_t;

    rd_t rq[$];
    wr_t wq[$];

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] last_r0 = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Dot product straight from the memory image, addresses wrapping at 2^AW
    function automatic int model(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                                 input int ln, input bit sgn);
        int s = 0;
        for (int i = 0; i < ln; i++) begin
            logic [AW-1:0]        aa;
            logic [AW-1:0]        ab;
            logic signed [DW-1:0] va;
            logic signed [DW-1:0] vb;
            aa = ba + AW'(i);
            ab = bb + AW'(i);
            va = mem[aa];
            vb = mem[ab];
            if (sgn) s += int'(va) * int'(vb);
            else     s += int'(mem[aa]) * int'(mem[ab]);
        end
        return s;
    endfunction

    // Queue the reads and the write that a request accepted in cycle t must produce
    task automatic expect_op(input int t, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                             input logic [AW-1:0] dst, input int ln,
                             input bit use_c, input int c0, input int c1);
        rd_t r;
        wr_t w;
        for (int i = 0; i < ln; i++) begin
            r.cyc = t + 1 + i;
            r.a   = ba + AW'(i);
            r.b   = bb + AW'(i);
            rq.push_back(r);
        end
        w.cyc  = (ln == 0) ? t + 1 : t + ln + 2;
        w.addr = dst;
        w.r0   = use_c ? RW'(c0) : RW'(model(ba, bb, ln, 1'b0));
        w.r1   = use_c ? RW'(c1) : RW'(model(ba, bb, ln, 1'b1));
        wq.push_back(w);
        last_r0 = w.r0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((wq.size() != 0 || rq.size() != 0) && k < 60) begin
            @(posedge clk);
            k++;
        end
        chk("scoreboard drained", wq.size() + rq.size(), 0);
        rq.delete();
        wq.delete();
        #1;
    endtask

    task automatic run_op(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                          input logic [AW-1:0] dst, input int ln,
                          input bit use_c, input int c0, input int c1);
        int t;
        @(posedge clk); #1;
        ba_s  = ba;
        bb_s  = bb;
        dst_s = dst;
        len_s = LW'(ln);
        start = 1'b1;
        t     = cyc;
        expect_op(t, ba, bb, dst, ln, use_c, c0, c1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after accept", int'(u_if0.busy), 1);
        chk("err cleared by accept", int'(u_if0.err), 0);
        wait_drain();
        chk("busy back to idle", int'(u_if0.busy), 0);
        chk("done one cycle", int'(u_if0.done), 0);
        chk("result held after write", int'(u_if0.result), int'(last_r0));
    endtask

    task automatic monitor();
        rd_t r;
        wr_t w;
        forever begin
            @(negedge clk);
            chk("rd/wr exclusive", int'(u_if0.mem_rd_en && u_if0.mem_wr_en), 0);
            if (u_if0.mem_rd_en) begin
                if (rq.size() == 0) begin
                    chk("unexpected read", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("read cycle", cyc, r.cyc);
                    chk("rd_addr_a", int'(u_if0.rd_addr_a), int'(r.a));
                    chk("rd_addr_b", int'(u_if0.rd_addr_b), int'(r.b));
                end
            end else if (rq.size() != 0 && rq[0].cyc < cyc) begin
                r = rq.pop_front();
                chk("missing read", cyc, r.cyc);
            end
            if (u_if0.done || u_if0.mem_wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected write/done", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("write cycle", cyc, w.cyc);
                    chk("done", int'(u_if0.done), 1);
                    chk("mem_wr_en", int'(u_if0.mem_wr_en), 1);
                    chk("wr_addr", int'(u_if0.wr_addr), int'(w.addr));
                    chk("result unsigned", int'(u_if0.result), int'(w.r0));
                    chk("done signed inst", int'(u_if1.done), 1);
                    chk("result signed", int'(u_if1.result), int'(w.r1));
                end
            end else if (wq.size() != 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                chk("missing write", cyc, w.cyc);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        int t;
        start = 1'b0;
        ba_s  = '0;
        bb_s  = '0;
        dst_s = '0;
        len_s = '0;
        for (int i = 0; i < MEMN; i++) mem[i] = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_rd_en", int'(u_if0.mem_rd_en), 0);
        chk("reset mem_wr_en", int'(u_if0.mem_wr_en), 0);
        chk("reset busy", int'(u_if0.busy), 0);
        chk("reset done", int'(u_if0.done), 0);
        chk("reset err", int'(u_if0.err), 0);
        chk("reset rd_addr_a", int'(u_if0.rd_addr_a), 0);
        chk("reset wr_addr", int'(u_if0.wr_addr), 0);
        chk("reset result", int'(u_if0.result), 0);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // worked example: 1..4 . 5..8
        for (int i = 0; i < 4; i++) begin
            mem[i]     = DW'(i + 1);
            mem[8 + i] = DW'(i + 5);
        end
        run_op(5'd0, 5'd8, 5'd20, 4, 1'b1, 70, 6);

        // extremes of the operand range
        for (int i = 0; i < 4; i++) begin
            mem[i] = 4'hF; mem[8 + i] = 4'hF;
        end
        run_op(5'd0, 5'd8, 5'd21, 4, 1'b1, 900, 4);
        for (int i = 0; i < 4; i++) begin
            mem[i] = 4'h8; mem[8 + i] = 4'h8;
        end
        run_op(5'd0, 5'd8, 5'd22, 4, 1'b1, 256, 256);
        for (int i = 0; i < 4; i++) begin
            mem[i] = 4'h8; mem[8 + i] = 4'h7;
        end
        run_op(5'd0, 5'd8, 5'd23, 4, 1'b1, 224, -224);

        // empty vector
        run_op(5'd0, 5'd8, 5'd5, 0, 1'b1, 0, 0);

        // over-length request is rejected
        @(posedge clk); #1;
        len_s = LW'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err on len>MAX", int'(u_if0.err), 1);
        chk("busy on len>MAX", int'(u_if0.busy), 0);
        chk("no read on len>MAX", int'(u_if0.mem_rd_en), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("err holds", int'(u_if0.err), 1);
        chk("result kept on err", int'(u_if0.result), int'(last_r0));

        // address wrap at top of memory
        fill_random();
        run_op(5'd30, 5'd3, 5'd9, 4, 1'b0, 0, 0);

        // reset in the middle of a fetch
        fill_random();
        @(posedge clk); #1;
        ba_s = 5'd0; bb_s = 5'd8; dst_s = 5'd20; len_s = LW'(4);
        start = 1'b1;
        t = cyc;
        for (int i = 0; i < 2; i++) begin
            rd_t r;
            r.cyc = t + 1 + i;
            r.a   = AW'(i);
            r.b   = AW'(8 + i);
            rq.push_back(r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun rst busy", int'(u_if0.busy), 0);
        chk("midrun rst rd_en", int'(u_if0.mem_rd_en), 0);
        chk("midrun rst rd_addr_a", int'(u_if0.rd_addr_a), 0);
        chk("midrun rst rd_addr_b", int'(u_if0.rd_addr_b), 0);
        chk("midrun rst result", int'(u_if0.result), 0);
        chk("midrun rst done", int'(u_if0.done), 0);
        chk("midrun rst signed busy", int'(u_if1.busy), 0);
        last_r0 = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("reads drained after rst", rq.size(), 0);
        run_op(5'd0, 5'd8, 5'd20, 4, 1'b0, 0, 0);

        // start held high: second run accepted the cycle after WRITE
        fill_random();
        @(posedge clk); #1;
        ba_s = 5'd2; bb_s = 5'd12; dst_s = 5'd7; len_s = LW'(3);
        start = 1'b1;
        t = cyc;
        expect_op(t, 5'd2, 5'd12, 5'd7, 3, 1'b0, 0, 0);
        expect_op(t + 6, 5'd2, 5'd12, 5'd7, 3, 1'b0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        chk("b2b busy idle", int'(u_if0.busy), 0);

        // random requests
        for (int n = 0; n < 20; n++) begin
            fill_random();
            run_op(AW'($urandom), AW'($urandom), AW'($urandom),
                   int'($urandom_range(0, MAX_LEN)), 1'b0, 0, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard empty at end", rq.size() + wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_dot_engine.md
VECTOR_DOT_ENGINE -- requirements
Module: vector_dot_engine

Interface
REQ-001 Parameter DW, default 4: element width in bits.
REQ-002 Parameter AW, default 5: memory address width.
REQ-003 Parameter MAX_LEN, default 4: maximum vector length; power of two, at least 2.
REQ-004 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 Derived widths: LW = $clog2(MAX_LEN)+1; RW = 2*DW + $clog2(MAX_LEN).
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request pulse; sampled only in IDLE.
REQ-009 base_a, base_b, dst_addr  in  AW each  vector A base, vector B base, result address.
REQ-010 len  in  LW  element count.
REQ-011 mem_rd_en  out  1  read strobe.
REQ-012 rd_addr_a, rd_addr_b  out  AW each  read addresses.
REQ-013 rd_data_a, rd_data_b  in  DW each  read data; valid exactly 1 cycle after mem_rd_en.
REQ-014 mem_wr_en  out  1  result write strobe.
REQ-015 wr_addr  out  AW  result write address.
REQ-016 result  out  RW  dot product.
REQ-017 busy, done, err  out  1 each  engine active; 1-cycle completion pulse; length-error flag.

Function
REQ-018 States: IDLE, FETCH, DRAIN, WRITE; the block SHALL have no other reachable states.
REQ-019 IDLE with start=1 and 1<=len<=MAX_LEN (cycle T): latch base_a, base_b, dst_addr, len; clear the accumulator and err; go to FETCH.
REQ-020 IDLE with start=1 and len=0: go to WRITE at T+1 with result=0; no read issued.
REQ-021 IDLE with start=1 and len>MAX_LEN: set err=1, stay in IDLE, issue no read or write, leave result unchanged.
REQ-022 FETCH element i (i=0..len-1), cycles T+1..T+len: mem_rd_en=1, rd_addr_a=base_a+i, rd_addr_b=base_b+i, both modulo 2^AW (wrap, no error).
REQ-023 One cycle after each read, the accumulator SHALL add rd_data_a*rd_data_b, full 2*DW product, sign-extended to RW if SIGNED=1, otherwise zero-extended.
REQ-024 FETCH -> DRAIN after element len-1 is issued; DRAIN (T+len+1) accumulates the last product with mem_rd_en=0.
REQ-025 DRAIN -> WRITE; WRITE (T+len+2) lasts one cycle and drives: mem_wr_en=1, wr_addr=latched dst_addr, done=1, result=final sum. Then -> IDLE.
REQ-026 result SHALL be registered and SHALL hold its value from WRITE until the next WRITE or reset.
REQ-027 RW SHALL hold any sum of MAX_LEN products without overflow; no saturation logic.
REQ-028 busy=1 in FETCH, DRAIN and WRITE; 0 in IDLE.
REQ-029 start while busy=1 SHALL be ignored, with no queuing.
REQ-030 err SHALL hold until the next accepted start or reset.
REQ-031 A start in the cycle after WRITE SHALL be accepted, giving back-to-back operation.
REQ-032 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.

Reset
REQ-033 rst=1 at any clock edge, including mid-FETCH, SHALL force IDLE with: result=0, accumulator=0, busy=0, done=0, err=0, mem_rd_en=0, mem_wr_en=0, rd_addr_a=0, rd_addr_b=0, wr_addr=0.
REQ-034 rst SHALL take priority over start; an operation interrupted by reset SHALL produce no write and no done pulse.

Verification
REQ-035 DW=4, SIGNED=0: mem[0..3]=1,2,3,4, mem[8..11]=5,6,7,8, base_a=0, base_b=8, dst_addr=20, len=4, start at T -> reads at T+1..T+4; at T+6 mem_wr_en=1, wr_addr=20, done=1, result=70.
REQ-036 All elements 15, len=4, SIGNED=0 -> result=900 (RW=10, no overflow); SIGNED=1 with all elements -8 (0x8) -> result=256; A=-8, B=7 -> result=-224.
REQ-037 len=0 at T -> done and mem_wr_en at T+1, result=0, mem_rd_en never high; len=5 -> err=1, busy stays 0, no memory activity.
REQ-038 base_a=30, len=4 -> rd_addr_a sequence 30,31,0,1.
REQ-039 rst asserted at T+2 of a len=4 run -> next cycle: IDLE, all outputs 0, no done or write; a fresh start then completes correctly.
REQ-040 start held high through a run -> second run accepted on the cycle after WRITE; done pulses 1 cycle each, result correct for both.
